// File: rtl/stream_fifo_pkg.sv
// Shared stream definitions for the Wishbone bridge -> FIFO -> Adder path.
//   STREAM_DATA_W : default beat width
//   stream_beat_t : one stream beat
//   ptr_inc       : circular pointer increment, wraps depth-1 -> 0
package stream_fifo_pkg;

   localparam int unsigned STREAM_DATA_W = 32;

   typedef struct packed {
      logic [STREAM_DATA_W-1:0] data;
   } stream_beat_t;

   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 32'd1 == depth) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Val/rdy stream handshake bundle.
//   val  : beat valid (master -> slave)
//   data : beat payload (master -> slave)
//   rdy  : slave accepts beat (slave -> master)
interface stream_fifo_if
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = STREAM_DATA_W
);

   logic              val;
   logic [DATA_W-1:0] data;
   logic              rdy;

   modport master (output val, output data, input rdy);
   modport slave  (input val, input data, output rdy);

endinterface

// File: rtl/stream_fifo_ram.sv
// DEPTH x DATA_W register array for stream_fifo.
//   clk   : write clock
//   reset : asynchronous active-low clear of every entry
//   we    : write enable, waddr/wdata : write port (sync)
//   raddr : read address, rdata : read data (async)
module stream_fifo_ram
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = STREAM_DATA_W,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Val/rdy elastic buffer between the Wishbone stream bridge and the Adder.
// Cuts the combinational rdy path: i_stream.rdy depends only on occupancy.
//   clk      : single clock, posedge
//   reset    : asynchronous active-low reset
//   i_stream : producer side (slave modport: val/data in, rdy out)
//   o_stream : consumer side (master modport: val/data out, rdy in)
//   count    : current occupancy 0..DEPTH
// Build option STREAM_FIFO_BYPASS_EN: when empty and both sides are ready the beat
// passes combinationally without being stored (min latency 0).
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = STREAM_DATA_W,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W  = ADDR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   stream_fifo_if.slave     i_stream,
   stream_fifo_if.master    o_stream,
   output logic [CNT_W-1:0] count
);

   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] ram_rdata;
   logic              full, empty, in_rdy, bypass, enq, deq;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   // Gated by reset so rdy is low for the whole time reset is asserted.
   assign in_rdy = reset & ~full;

`ifdef STREAM_FIFO_BYPASS_EN
   assign bypass = reset & empty & i_stream.val & o_stream.rdy;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed beat is neither written nor popped.
   assign enq = i_stream.val & in_rdy & ~bypass;
   assign deq = ~empty & o_stream.rdy;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (enq) begin
         wr_ptr_d = ADDR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (deq) begin
         rd_ptr_d = ADDR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   stream_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (enq),
      .waddr (wr_ptr_q),
      .wdata (i_stream.data),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign i_stream.rdy  = in_rdy;
   assign o_stream.val  = ~empty | bypass;
   assign o_stream.data = bypass ? i_stream.data : ram_rdata;
   assign count         = count_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DEPTH=4, DATA_W=32) against a queue model.
module tb_stream_fifo;
   import stream_fifo_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 3;
`ifdef STREAM_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] count;

   stream_fifo_if #(.DATA_W(DATA_W)) in_if ();
   stream_fifo_if #(.DATA_W(DATA_W)) out_if ();

   stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_stream (in_if),
      .o_stream (out_if),
      .count    (count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_q [$];
   logic [31:0] out_log [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, sample at negedge against the model, advance model at posedge.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r);
      int sz;
      bit byp;
      in_if.val   = v;
      in_if.data  = d;
      out_if.rdy  = r;
      @(negedge clk);
      sz  = model_q.size();
      byp = BYP && (sz == 0) && v && r;
      check_eq("i_rdy", 64'(in_if.rdy), 64'(sz != int'(DEPTH)));
      check_eq("count", 64'(count), 64'(sz));
      check_eq("o_val", 64'(out_if.val), 64'((sz != 0) || byp));
      if (byp) check_eq("o_data_byp", 64'(out_if.data), 64'(d));
      else if (sz != 0) check_eq("o_data", 64'(out_if.data), 64'(model_q[0]));
      if (out_if.val && r) out_log.push_back(out_if.data);
      @(posedge clk);
      if (!byp) begin
         if (sz != 0 && r) void'(model_q.pop_front());
         if (v && sz != int'(DEPTH)) model_q.push_back(d);
      end
      #1;
   endtask

   task automatic idle_check(input string tag, input int exp_cnt, input logic [31:0] exp_data,
                             input logic exp_val, input logic exp_rdy);
      in_if.val  = 1'b0;
      out_if.rdy = 1'b0;
      @(negedge clk);
      check_eq({tag, "_count"}, 64'(count), 64'(exp_cnt));
      check_eq({tag, "_oval"}, 64'(out_if.val), 64'(exp_val));
      if (exp_val) check_eq({tag, "_odata"}, 64'(out_if.data), 64'(exp_data));
      check_eq({tag, "_irdy"}, 64'(in_if.rdy), 64'(exp_rdy));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_drain [5];
      exp_drain[0] = 32'h11; exp_drain[1] = 32'h22; exp_drain[2] = 32'h33;
      exp_drain[3] = 32'h44; exp_drain[4] = 32'h55;

      reset      = 1'b0;
      in_if.val  = 1'b0;
      in_if.data = '0;
      out_if.rdy = 1'b0;

      // Reset state
      @(negedge clk);
      check_eq("rst_oval", 64'(out_if.val), 64'd0);
      check_eq("rst_odata", 64'(out_if.data), 64'd0);
      check_eq("rst_irdy", 64'(in_if.rdy), 64'd0);
      check_eq("rst_count", 64'(count), 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // 1. Three pushes, consumer stalled
      cycle(1'b1, 32'h11, 1'b0);
      cycle(1'b1, 32'h22, 1'b0);
      cycle(1'b1, 32'h33, 1'b0);
      idle_check("t1", 3, 32'h11, 1'b1, 1'b1);

      // 2. Fill, hold 0x55 while full, single-cycle drain, then full drain
      out_log.delete();
      cycle(1'b1, 32'h44, 1'b0);
      cycle(1'b1, 32'h55, 1'b0);
      cycle(1'b1, 32'h55, 1'b0);
      cycle(1'b1, 32'h55, 1'b1);
      cycle(1'b1, 32'h55, 1'b0);
      idle_check("t2_full", 4, 32'h22, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
      check_eq("t2_drain_len", 64'(out_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < out_log.size(); i++)
         check_eq("t2_drain_order", 64'(out_log[i]), 64'(exp_drain[i]));

      // 3. Streaming 0..19 with both sides always ready
      out_log.delete();
      for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      check_eq("t3_len", 64'(out_log.size()), 64'd20);
      for (int i = 0; i < 20 && i < out_log.size(); i++)
         check_eq("t3_order", 64'(out_log[i]), 64'(i));

      // 4. Random traffic against the model
      for (int i = 0; i < 2000; i++)
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      for (int i = 0; i < int'(DEPTH) + 1; i++) cycle(1'b0, 32'h0, 1'b1);
      check_eq("t4_empty", 64'(count), 64'd0);

      // 5. Asynchronous reset with three beats in flight
      cycle(1'b1, 32'hA1, 1'b0);
      cycle(1'b1, 32'hA2, 1'b0);
      cycle(1'b1, 32'hA3, 1'b0);
      in_if.val = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("t5_oval", 64'(out_if.val), 64'd0);
      check_eq("t5_irdy", 64'(in_if.rdy), 64'd0);
      check_eq("t5_count", 64'(count), 64'd0);
      check_eq("t5_odata", 64'(out_if.data), 64'd0);
      model_q.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_eq("t5_rel_irdy", 64'(in_if.rdy), 64'd1);
      check_eq("t5_rel_oval", 64'(out_if.val), 64'd0);
      check_eq("t5_rel_odata", 64'(out_if.data), 64'd0);
      @(posedge clk);
      #1;
      out_log.delete();
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h77, 1'b0);
      cycle(1'b0, 32'h0, 1'b1);
      check_eq("t5_no_stale_len", 64'(out_log.size()), 64'd1);
      if (out_log.size() > 0) check_eq("t5_no_stale", 64'(out_log[0]), 64'h77);

      // 6. Empty FIFO, both sides ready: same-cycle with bypass, next cycle without
      out_log.delete();
      cycle(1'b1, 32'hDEADBEEF, 1'b1);
      check_eq("t6_first_cycle", 64'(out_log.size()), 64'(BYP));
      cycle(1'b0, 32'h0, 1'b1);
      check_eq("t6_len", 64'(out_log.size()), 64'd1);
      if (out_log.size() > 0) check_eq("t6_data", 64'(out_log[0]), 64'hDEADBEEF);
      check_eq("t6_count", 64'(count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
